bgp_enable_sequencer: RTL

Upstream power-up sequencer for the 3.3 V bandgap reference macro in the user project area. Takes a level enable request from the management SoC (logic analyzer or wishbone-driven register) and drives the bandgap EN pin. Times a fixed settling interval before declaring the reference voltage valid, and enforces a minimum off-time before any re-enable. Downstream analog consumers (ADC/DAC/comparators) gate on bgp_ready.

---
 rtl/bgp_enable_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/bgp_enable_sequencer.sv
// Bandgap EN sequencer: timed settle before bgp_ready, enforced minimum off-time.
// Optional bgp_ok supervision with a FAULT state when BGP_SEQ_OKCHK_EN is defined.
module bgp_enable_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned OFF_CYCLES    = 8,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       en_req,
`ifdef BGP_SEQ_OKCHK_EN
  input  logic       bgp_ok,
`endif
  output logic       bgp_en,
  output logic       bgp_ready,
  output logic       ready_pulse,
  output logic       busy,
  output logic [1:0] state,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_OFF,
    S_STARTUP,
    S_READY,
    S_COOLDOWN
`ifdef BGP_SEQ_OKCHK_EN
    , S_FAULT
`endif
  } seq_state_t;

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD    = CNT_W'(OFF_CYCLES - 1);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       state_enc_d;

`ifdef BGP_SEQ_OKCHK_EN
  // Remembers one sampled bgp_ok=0 in READY; a second consecutive low trips FAULT.
  logic ok_low_q, ok_low_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef BGP_SEQ_OKCHK_EN
    ok_low_d = 1'b0;
`endif
    case (state_q)
      S_OFF: begin
        if (en_req) begin
          state_d = S_STARTUP;
          cnt_d   = SETTLE_LOAD;
        end
      end
      S_STARTUP: begin
        if (!en_req) begin
          state_d = S_COOLDOWN;
          cnt_d   = OFF_LOAD;
        end else if (cnt_q == '0) begin
`ifdef BGP_SEQ_OKCHK_EN
          state_d = bgp_ok ? S_READY : S_FAULT;
`else
          state_d = S_READY;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_READY: begin
        if (!en_req) begin
          state_d = S_COOLDOWN;
          cnt_d   = OFF_LOAD;
        end
`ifdef BGP_SEQ_OKCHK_EN
        else if (!bgp_ok) begin
          if (ok_low_q) state_d = S_FAULT;
          else          ok_low_d = 1'b1;
        end
`endif
      end
      S_COOLDOWN: begin
        if (cnt_q == '0) state_d = S_OFF;
        else             cnt_d   = cnt_q - 1'b1;
      end
`ifdef BGP_SEQ_OKCHK_EN
      S_FAULT: begin
        if (!en_req) begin
          state_d = S_COOLDOWN;
          cnt_d   = OFF_LOAD;
        end
      end
`endif
      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    state_enc_d = 2'd0;
    case (state_d)
      S_STARTUP:  state_enc_d = 2'd1;
      S_READY:    state_enc_d = 2'd2;
      S_COOLDOWN: state_enc_d = 2'd3;
`ifdef BGP_SEQ_OKCHK_EN
      S_FAULT:    state_enc_d = 2'd3;
`endif
      default:    state_enc_d = 2'd0;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_OFF;
      cnt_q       <= '0;
      bgp_en      <= 1'b0;
      bgp_ready   <= 1'b0;
      ready_pulse <= 1'b0;
      busy        <= 1'b0;
      state       <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bgp_en      <= (state_d == S_STARTUP) || (state_d == S_READY);
      bgp_ready   <= (state_d == S_READY);
      ready_pulse <= (state_d == S_READY) && (state_q != S_READY);
      busy        <= (state_d == S_STARTUP) || (state_d == S_COOLDOWN);
      state       <= state_enc_d;
    end
  end

`ifdef BGP_SEQ_OKCHK_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ok_low_q <= 1'b0;
      fault    <= 1'b0;
    end else begin
      ok_low_q <= ok_low_d;
      fault    <= (state_d == S_FAULT);
    end
  end
`else
  assign fault = 1'b0;
`endif

endmodule
